booth_issue_seq: RTL
====================

# booth_issue_seq

Operand-issue sequencer that sits directly upstream of the Booth multiplier datapath. It accepts operand pairs over a valid/ready handshake, holds them stable on the multiplier's operand inputs, and pulses `start`. It then waits for the multiplier's level `done` and captures the product into an output register drained over a second valid/ready handshake. It turns the multiplier's start/done protocol into a back-pressured stream for the surrounding design.

## Interface
- `N`, 16: multiplicand width.
- `M`, 16: multiplier width.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only when `BOOTH_SEQ_TIMEOUT_EN` is defined; must be greater than M+4.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high. Shared with the multiplier datapath.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  sequencer can accept an operand pair.
- `in_multiplicand`  in  N  signed multiplicand.
- `in_multiplier`  in  M  signed multiplier.
- `mul_start`  out  1  start pulse to the multiplier.
- `mul_multiplicand`  out  N+1  sign-extended held multiplicand.
- `mul_multiplier`  out  M+1  sign-extended held multiplier.
- `mul_product`  in  M+N  product from the multiplier.
- `mul_done`  in  1  registered level done from the multiplier.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer takes result.
- `res_product`  out  M+N  captured product.
- `res_timeout`  out  1  result was produced by the watchdog. Constant 0 without the macro.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, START, WAIT, CAPTURE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`: load the operand registers (sign-extended by one bit), clear `armed`, go to START.
- **START**
  - `mul_start` = 1 for exactly this one cycle.
  - Operand registers stay frozen until the next accept.
  - Next state: WAIT.
- **WAIT**
  - `armed` sets on any cycle with `mul_done` = 0. This discards a stale done level left over from the previous operation.
  - When `armed` = 1 and `mul_done` = 1: go to CAPTURE.
- **CAPTURE**
  - If `res_valid` = 0 or `res_ready` = 1: load `res_product` from `mul_product`, set `res_valid` = 1, clear `res_timeout`, go to IDLE.
  - Otherwise stall in CAPTURE. The multiplier holds its product while idle, so `mul_product` stays valid.
- **Output handshake**
  - `res_valid` clears on `res_ready` unless a capture happens in the same cycle.
  - `res_product` is unchanged while `res_valid` = 1 and `res_ready` = 0.
- **Arithmetic**
  - No arithmetic is performed in this block.
  - Width extension: `mul_multiplicand` = {msb, operand}, likewise for the multiplier.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready` 1 (combinational from state).
  - `mul_start` 0.
  - `mul_multiplicand` 0, `mul_multiplier` 0.
  - `res_valid` 0, `res_product` 0, `res_timeout` 0.
  - `busy` 0.
  - `armed` 0, watchdog counter 0.
- Accept at edge t puts `mul_start` high during cycle t+1; WAIT begins at t+2.
- `mul_done` sampled 1 with `armed` at edge k gives CAPTURE at k+1 and `res_valid` high from k+2 (no stall).
- Throughput: one operation per (multiplier latency + 4) cycles. At most one operation is in flight.
- Simultaneous `res_ready` and capture: old result retires, new one loads, `res_valid` stays 1.
- `in_valid` while not IDLE: ignored, since `in_ready` = 0. The source must hold the data.
- `rst` mid-operation: everything returns to the reset values at the next edge. Any in-flight operation and held result are discarded.
- `mul_start` and `in_ready` are never high in the same cycle.

## Configuration
- `BOOTH_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entering START.
  - When the count reaches `TIMEOUT` without a qualifying done, go to CAPTURE as a forced result.
  - A forced capture loads `res_product` = 0 and `res_timeout` = 1.
  - `res_timeout` stays 1 until that result is consumed.
- Not defined: no counter; WAIT lasts indefinitely; `res_timeout` is tied to 0.

## Test plan
- **Basic signed product:** multiplicand 3, multiplier -5, `res_ready` = 1 → one `mul_start` pulse, `mul_multiplicand` = 17'h00003, `mul_multiplier` = 17'h1FFFB; `res_product` = 32'hFFFFFFF1, `res_valid` high 2 cycles after the done edge.
- **Back-pressure:** two operations with `res_ready` = 0 → second product stalls in CAPTURE, `in_ready` = 0. Raising `res_ready` retires the first and loads the second in the same cycle, with `res_valid` continuously 1.
- **Stale done:** `mul_done` held 1 across a new `mul_start` → no capture until `mul_done` drops and rises again.
- **Reset mid-WAIT:** assert `rst` for one cycle → next cycle state IDLE, `res_valid` 0, `in_ready` 1, `mul_start` 0.
- **Timeout (macro on, TIMEOUT = 64, `mul_done` stuck 0):** `res_valid` = 1 with `res_product` 0 and `res_timeout` 1, at 66 cycles after START (64 counted cycles in WAIT + 2). Without the macro, `busy` stays 1 indefinitely.

Source files
------------

// File: rtl/booth_issue_seq.sv
// Operand-issue sequencer wrapping a Booth multiplier start/done port in valid/ready streams.
// Optional watchdog: define BOOTH_SEQ_TIMEOUT_EN to force a timeout result after TIMEOUT wait cycles.
module booth_issue_seq #(
  parameter int N       = 16,
  parameter int M       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_multiplicand,
  input  logic [M-1:0]   in_multiplier,
  output logic           mul_start,
  output logic [N:0]     mul_multiplicand,
  output logic [M:0]     mul_multiplier,
  input  logic [M+N-1:0] mul_product,
  input  logic           mul_done,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [M+N-1:0] res_product,
  output logic           res_timeout,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    CAPTURE
  } state_t;

  state_t state, state_nx;
  logic   armed;
  logic   accept;
  logic   cap_en;
  logic   forced;
  logic   to_hit;

  if (TIMEOUT <= M + 4) begin : g_bad_timeout
    $error("TIMEOUT must exceed M+4");
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if ((armed && mul_done) || to_hit) state_nx = CAPTURE;
      CAPTURE: if (cap_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    mul_start = (state == START);
    busy      = (state != IDLE);
    accept    = (state == IDLE) && in_valid;
    cap_en    = (state == CAPTURE) && (!res_valid || res_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      armed            <= 1'b0;
      res_valid        <= 1'b0;
      res_product      <= '0;
    end else begin
      if (accept) begin
        mul_multiplicand <= {in_multiplicand[N-1], in_multiplicand};
        mul_multiplier   <= {in_multiplier[M-1], in_multiplier};
        armed            <= 1'b0;
      end else if (state == WAIT && !mul_done) begin
        // a done seen before any low level is left over from the last op
        armed <= 1'b1;
      end
      if (cap_en) begin
        res_valid   <= 1'b1;
        res_product <= forced ? '0 : mul_product;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;

  // the TIMEOUT-th wait cycle is the last one spent in WAIT
  assign to_hit = (state == WAIT) && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      forced      <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (accept)              wd_cnt <= '0;
      else if (state == WAIT)  wd_cnt <= wd_cnt + CW'(1);
      if (state == WAIT)
        forced <= to_hit && !(armed && mul_done);
      if (cap_en)              res_timeout <= forced;
      else if (res_ready)      res_timeout <= 1'b0;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign forced      = 1'b0;
  assign res_timeout = 1'b0;
`endif

endmodule
